// File: rtl/isolde_xif_result_arbiter_if.sv
// rtl/isolde_xif_result_arbiter_if.sv - coprocessor-side and CPU-side XIF result signals of the arbiter
interface isolde_xif_result_arbiter_if #(
   parameter int N_PORTS  = 2,
   parameter int RESULT_W = 60,
   parameter int SRC_W    = $clog2(N_PORTS)
);
   logic [N_PORTS-1:0]          cp_result_valid_i;
   logic [N_PORTS-1:0]          cp_result_ready_o;
   logic [N_PORTS*RESULT_W-1:0] cp_result_i;
   logic                        cpu_result_valid_o;
   logic                        cpu_result_ready_i;
   logic [RESULT_W-1:0]         cpu_result_o;
   logic [SRC_W-1:0]            cpu_result_src_o;
   logic                        busy_o;

   modport slave (
      input  cp_result_valid_i, cp_result_i, cpu_result_ready_i,
      output cp_result_ready_o, cpu_result_valid_o, cpu_result_o, cpu_result_src_o, busy_o
   );

   modport master (
      output cp_result_valid_i, cp_result_i, cpu_result_ready_i,
      input  cp_result_ready_o, cpu_result_valid_o, cpu_result_o, cpu_result_src_o, busy_o
   );
endinterface

// File: rtl/isolde_xif_result_arbiter.sv
// rtl/isolde_xif_result_arbiter.sv - round-robin merge of N coprocessor XIF result channels into one buffered CPU result channel
module isolde_xif_result_arbiter #(
   parameter int N_PORTS  = 2,
   parameter int RESULT_W = 60,
   parameter int SRC_W    = $clog2(N_PORTS)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   isolde_xif_result_arbiter_if.slave   xif
);

   logic                out_valid_q, out_valid_d;
   logic [RESULT_W-1:0] out_data_q,  out_data_d;
   logic [SRC_W-1:0]    out_src_q,   out_src_d;
   logic [SRC_W-1:0]    rr_ptr_q,    rr_ptr_d;

   logic                load_en;
   logic                grant_found;
   logic                grant;
   logic [SRC_W-1:0]    grant_idx;
   logic [SRC_W-1:0]    cand_idx;
   logic [N_PORTS-1:0]  cp_ready;
   int                  cand;

   assign load_en = !out_valid_q || xif.cpu_result_ready_i;
   assign grant   = load_en && grant_found;

   // Scan ports starting at rr_ptr, wrapping modulo N_PORTS; first valid port wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         cand     = (int'(rr_ptr_q) + i) % N_PORTS;
         cand_idx = SRC_W'(cand);
         if (!grant_found && xif.cp_result_valid_i[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      cp_ready = '0;
      if (!rst_i && grant) begin
         cp_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (grant) begin
         out_valid_d = 1'b1;
         out_data_d  = xif.cp_result_i[int'(grant_idx)*RESULT_W +: RESULT_W];
         out_src_d   = grant_idx;
         rr_ptr_d    = (grant_idx == SRC_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end else if (xif.cpu_result_ready_i) begin
         // Drain with nothing to replace it: buffer empties.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign xif.cp_result_ready_o  = cp_ready;
   assign xif.cpu_result_valid_o = out_valid_q;
   assign xif.cpu_result_o       = out_data_q;
   assign xif.cpu_result_src_o   = out_src_q;
   assign xif.busy_o             = out_valid_q;

endmodule

// File: tb/tb_isolde_xif_result_arbiter.sv
// tb/tb_isolde_xif_result_arbiter.sv - self-checking bench for isolde_xif_result_arbiter
module tb_isolde_xif_result_arbiter;

   logic clk;
   logic rst2;
   logic rst4;
   int   n_checks;
   int   n_pass;

   isolde_xif_result_arbiter_if #(.N_PORTS(2), .RESULT_W(60)) bus2 ();
   isolde_xif_result_arbiter_if #(.N_PORTS(4), .RESULT_W(60)) bus4 ();

   isolde_xif_result_arbiter #(.N_PORTS(2), .RESULT_W(60)) dut2 (
      .clk_i (clk),
      .rst_i (rst2),
      .xif   (bus2)
   );

   isolde_xif_result_arbiter #(.N_PORTS(4), .RESULT_W(60)) dut4 (
      .clk_i (clk),
      .rst_i (rst4),
      .xif   (bus4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic        cr;
      logic [3:0]  exp_ready;
      logic        exp_ov;
      logic [1:0]  exp_src;
      logic [59:0] exp_data;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(input int r, input int v, input int cr, input int er,
                               input int ov, input int src, input int data);
      vec_t m;
      m.rst       = r[0];
      m.valid     = v[3:0];
      m.cr        = cr[0];
      m.exp_ready = er[3:0];
      m.exp_ov    = ov[0];
      m.exp_src   = src[1:0];
      m.exp_data  = 60'(data);
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   // Reference winner: the valid port at the smallest rotational distance from the pointer.
   function automatic int rr_pick(input logic [3:0] v, input int ptr);
      int best;
      int bestd;
      int d;
      best  = -1;
      bestd = 99;
      for (int p = 0; p < 4; p++) begin
         d = (p - ptr + 4) % 4;
         if (v[p] && d < bestd) begin
            bestd = d;
            best  = p;
         end
      end
      return best;
   endfunction

   logic [239:0] words4;
   logic         m_ov;
   logic [59:0]  m_data;
   int           m_src;
   int           m_ptr;
   int           w;
   logic         le;
   logic [3:0]   exp_ready;
   logic [3:0]   rv;
   logic         rcr;
   logic         rrst;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst2 = 1'b1;
      rst4 = 1'b1;
      bus2.cp_result_valid_i  = 2'b11;
      bus2.cp_result_i        = {60'h0ABC, 60'h0123};
      bus2.cpu_result_ready_i = 1'b1;
      bus4.cp_result_valid_i  = '0;
      bus4.cp_result_i        = '0;
      bus4.cpu_result_ready_i = 1'b0;

      // Two-port block: reset with all valids, then single requester on port 1.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         #1;
         check("n2_rst_ready", 64'(bus2.cp_result_ready_o), 64'h0);
         @(posedge clk);
         #1;
         check("n2_rst_valid", 64'(bus2.cpu_result_valid_o), 64'h0);
      end
      @(negedge clk);
      rst2 = 1'b0;
      bus2.cp_result_valid_i = 2'b10;
      #1;
      check("n2_single_ready", 64'(bus2.cp_result_ready_o), 64'h2);
      @(posedge clk);
      #1;
      check("n2_single_valid", 64'(bus2.cpu_result_valid_o), 64'h1);
      check("n2_single_data", 64'(bus2.cpu_result_o), 64'h0ABC);
      check("n2_single_src", 64'(bus2.cpu_result_src_o), 64'h1);
      check("n2_single_busy", 64'(bus2.busy_o), 64'h1);

      // Four-port directed sequence.
      tbl[0]  = mk(1, 'hF, 1, 0, 0, 0, 0);
      tbl[1]  = mk(1, 'hF, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 'hF, 1, 1, 1, 0, 'hA00);
      tbl[3]  = mk(0, 'hF, 1, 2, 1, 1, 'hA01);
      tbl[4]  = mk(0, 'hF, 1, 4, 1, 2, 'hA02);
      tbl[5]  = mk(0, 'hF, 1, 8, 1, 3, 'hA03);
      tbl[6]  = mk(0, 'hF, 1, 1, 1, 0, 'hA00);
      tbl[7]  = mk(0, 'hF, 1, 2, 1, 1, 'hA01);
      tbl[8]  = mk(0, 'hF, 1, 4, 1, 2, 'hA02);
      tbl[9]  = mk(0, 'hF, 1, 8, 1, 3, 'hA03);
      tbl[10] = mk(0, 'hF, 0, 0, 1, 3, 'hA03);
      tbl[11] = mk(0, 'hF, 0, 0, 1, 3, 'hA03);
      tbl[12] = mk(0, 'hF, 0, 0, 1, 3, 'hA03);
      tbl[13] = mk(0, 'hF, 1, 1, 1, 0, 'hA00);
      tbl[14] = mk(0, 'h0, 1, 0, 0, 0, 'hA00);
      tbl[15] = mk(0, 'h0, 0, 0, 0, 0, 'hA00);
      tbl[16] = mk(0, 'h4, 0, 4, 1, 2, 'hA02);
      tbl[17] = mk(0, 'h8, 0, 0, 1, 2, 'hA02);
      tbl[18] = mk(1, 'h8, 1, 0, 0, 0, 0);
      tbl[19] = mk(0, 'hA, 1, 2, 1, 1, 'hA01);
      tbl[20] = mk(0, 'h8, 1, 8, 1, 3, 'hA03);
      tbl[21] = mk(0, 'h9, 1, 1, 1, 0, 'hA00);
      tbl[22] = mk(0, 'h9, 1, 8, 1, 3, 'hA03);

      for (int p = 0; p < 4; p++) words4[p*60 +: 60] = 60'hA00 + 60'(p);
      bus4.cp_result_i = words4;

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         rst4 = tbl[i].rst;
         bus4.cp_result_valid_i  = tbl[i].valid;
         bus4.cpu_result_ready_i = tbl[i].cr;
         #1;
         check($sformatf("tbl%0d_ready", i), 64'(bus4.cp_result_ready_o), 64'(tbl[i].exp_ready));
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_valid", i), 64'(bus4.cpu_result_valid_o), 64'(tbl[i].exp_ov));
         check($sformatf("tbl%0d_busy", i), 64'(bus4.busy_o), 64'(tbl[i].exp_ov));
         check($sformatf("tbl%0d_src", i), 64'(bus4.cpu_result_src_o), 64'(tbl[i].exp_src));
         check($sformatf("tbl%0d_data", i), 64'(bus4.cpu_result_o), 64'(tbl[i].exp_data));
      end

      // Randomized traffic against the reference model.
      m_ov   = 1'b0;
      m_data = '0;
      m_src  = 0;
      m_ptr  = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rrst = (c == 0) || ($urandom_range(0, 49) == 0);
         rv   = 4'($urandom_range(0, 15));
         rcr  = ($urandom_range(0, 9) < 7);
         for (int p = 0; p < 4; p++) words4[p*60 +: 60] = {28'($urandom), $urandom};
         rst4 = rrst;
         bus4.cp_result_valid_i  = rv;
         bus4.cpu_result_ready_i = rcr;
         bus4.cp_result_i        = words4;

         le = !m_ov || rcr;
         w  = rr_pick(rv, m_ptr);
         exp_ready = 4'h0;
         if (!rrst && le && w >= 0) exp_ready[w] = 1'b1;
         #1;
         check($sformatf("rnd%0d_ready", c), 64'(bus4.cp_result_ready_o), 64'(exp_ready));

         if (rrst) begin
            m_ov = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
         end else if (le && w >= 0) begin
            m_ov   = 1'b1;
            m_data = words4[w*60 +: 60];
            m_src  = w;
            m_ptr  = (w + 1) % 4;
         end else if (rcr) begin
            m_ov = 1'b0;
         end
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d_valid", c), 64'(bus4.cpu_result_valid_o), 64'(m_ov));
         check($sformatf("rnd%0d_src", c), 64'(bus4.cpu_result_src_o), 64'(m_src));
         check($sformatf("rnd%0d_data", c), 64'(bus4.cpu_result_o), 64'(m_data));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
